// File: rtl/hazard_pkg.sv
// Shared types and constants for the execute-stage hazard controller.
// Scoreboard saturation limit, redirect flush lengths and the count update helper.
package hazard_pkg;

    typedef enum logic [0:0] {
        StIdle  = 1'b0,
        StFlush = 1'b1
    } state_e;

    localparam int unsigned NUM_REGS = 32;

    localparam logic [1:0] FLUSH_LEN_BR   = 2'd2;
    localparam logic [1:0] FLUSH_LEN_JALR = 2'd2;
    localparam logic [1:0] FLUSH_LEN_J    = 2'd1;
    localparam logic [1:0] SB_CNT_MAX     = 2'd3;

    // Net change of one pending count: +inc, -dec, clamped to [0, SB_CNT_MAX].
    function automatic logic [1:0] sb_next(logic [1:0] cnt, logic inc, logic [1:0] dec);
        logic [2:0] sum;
        logic [2:0] res;
        sum = {1'b0, cnt} + {2'b00, inc};
        if (sum <= {1'b0, dec}) begin
            res = 3'd0;
        end else begin
            res = sum - {1'b0, dec};
        end
        if (res > {1'b0, SB_CNT_MAX}) begin
            res = {1'b0, SB_CNT_MAX};
        end
        return res[1:0];
    endfunction

endpackage

// File: rtl/exec_hazard_ctrl_if.sv
// Decode/redirect/writeback bundle between the pipeline and exec_hazard_ctrl.
// Optional perf counter outputs appear when EXEC_HAZARD_PERF_CNT_EN is defined.
interface exec_hazard_ctrl_if;

    logic       instr_valid;
    logic [5:0] reg_rd_id;
    logic [4:0] rs1_id;
    logic [4:0] rs2_id;
    logic       resolve;
    logic       select_target_pc;
    logic       squash_after_J;
    logic       squash_after_JALR;
    logic       wb_valid;
    logic [4:0] wb_rd_id;
    logic       kill_valid;
    logic [4:0] kill_rd_id;
    logic       issue;
    logic       stall;
    logic       flush;
`ifdef EXEC_HAZARD_PERF_CNT_EN
    logic [31:0] stall_cnt;
    logic [31:0] flush_cnt;
`endif

    modport master (
        output instr_valid, reg_rd_id, rs1_id, rs2_id,
        output resolve, select_target_pc, squash_after_J, squash_after_JALR,
        output wb_valid, wb_rd_id, kill_valid, kill_rd_id,
        input  issue, stall, flush
`ifdef EXEC_HAZARD_PERF_CNT_EN
        , input stall_cnt, flush_cnt
`endif
    );

    modport slave (
        input  instr_valid, reg_rd_id, rs1_id, rs2_id,
        input  resolve, select_target_pc, squash_after_J, squash_after_JALR,
        input  wb_valid, wb_rd_id, kill_valid, kill_rd_id,
        output issue, stall, flush
`ifdef EXEC_HAZARD_PERF_CNT_EN
        , output stall_cnt, flush_cnt
`endif
    );

endinterface

// File: rtl/hazard_scoreboard.sv
// Per-register pending-write counters (x1..x31) with issue increment,
// writeback/kill decrement and three read ports for hazard lookup.
module hazard_scoreboard
    import hazard_pkg::*;
(
    input  logic       clk,
    input  logic       rst,
    input  logic       inc_en,
    input  logic [4:0] inc_idx,
    input  logic       wb_valid,
    input  logic [4:0] wb_idx,
    input  logic       kill_valid,
    input  logic [4:0] kill_idx,
    input  logic [4:0] rs1_idx,
    input  logic [4:0] rs2_idx,
    input  logic [4:0] rd_idx,
    output logic [1:0] rs1_cnt,
    output logic [1:0] rs2_cnt,
    output logic [1:0] rd_cnt
);

    logic [1:0] cnt_q [NUM_REGS];
    logic [1:0] cnt_d [NUM_REGS];

    always_comb begin
        for (int r = 0; r < NUM_REGS; r++) begin
            cnt_d[r] = cnt_q[r];
        end
        // x0 is hardwired: never pending regardless of traffic naming it.
        cnt_d[0] = 2'd0;
        for (int r = 1; r < NUM_REGS; r++) begin
            cnt_d[r] = sb_next(cnt_q[r],
                               inc_en && (inc_idx == 5'(r)),
                               {1'b0, wb_valid && (wb_idx == 5'(r))} +
                               {1'b0, kill_valid && (kill_idx == 5'(r))});
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int r = 0; r < NUM_REGS; r++) begin
                cnt_q[r] <= 2'd0;
            end
        end else begin
            for (int r = 0; r < NUM_REGS; r++) begin
                cnt_q[r] <= cnt_d[r];
            end
        end
    end

    assign rs1_cnt = cnt_q[rs1_idx];
    assign rs2_cnt = cnt_q[rs2_idx];
    assign rd_cnt  = cnt_q[rd_idx];

endmodule

// File: rtl/exec_hazard_ctrl.sv
// Issue/stall/flush control for the execute stage: scoreboard hazards plus redirect flush FSM.
// Define EXEC_HAZARD_PERF_CNT_EN to add 32-bit stall/flush cycle counters.
module exec_hazard_ctrl
    import hazard_pkg::*;
(
    input logic               clk,
    input logic               rst,
    exec_hazard_ctrl_if.slave bus
);

    state_e     state_q, state_d;
    logic [1:0] flush_left_q, flush_left_d;

    logic       issue, stall, flush;
    logic       rd_we;
    logic [4:0] rd_idx;
    logic [1:0] rs1_cnt, rs2_cnt, rd_cnt;
    logic       src_hazard, rd_full;
    logic [1:0] ev_len;
    logic       inc_en;

    assign rd_we  = bus.reg_rd_id[5];
    assign rd_idx = bus.reg_rd_id[4:0];

    hazard_scoreboard u_scoreboard (
        .clk        (clk),
        .rst        (rst),
        .inc_en     (inc_en),
        .inc_idx    (rd_idx),
        .wb_valid   (bus.wb_valid),
        .wb_idx     (bus.wb_rd_id),
        .kill_valid (bus.kill_valid),
        .kill_idx   (bus.kill_rd_id),
        .rs1_idx    (bus.rs1_id),
        .rs2_idx    (bus.rs2_id),
        .rd_idx     (rd_idx),
        .rs1_cnt    (rs1_cnt),
        .rs2_cnt    (rs2_cnt),
        .rd_cnt     (rd_cnt)
    );

    assign src_hazard = ((bus.rs1_id != 5'd0) && (rs1_cnt != 2'd0)) ||
                        ((bus.rs2_id != 5'd0) && (rs2_cnt != 2'd0));
    assign rd_full    = rd_we && (rd_cnt == SB_CNT_MAX);
    assign inc_en     = issue && rd_we && (rd_idx != 5'd0);

    // Redirect priority: taken branch > JALR > J; zero means no redirect.
    always_comb begin
        ev_len = 2'd0;
        if (bus.resolve && bus.select_target_pc) begin
            ev_len = FLUSH_LEN_BR;
        end else if (bus.squash_after_JALR) begin
            ev_len = FLUSH_LEN_JALR;
        end else if (bus.squash_after_J) begin
            ev_len = FLUSH_LEN_J;
        end
    end

    always_comb begin
        state_d      = state_q;
        flush_left_d = flush_left_q;
        issue        = 1'b0;
        stall        = 1'b0;
        flush        = 1'b0;
        unique case (state_q)
            StIdle: begin
                stall = bus.instr_valid && (src_hazard || rd_full);
                issue = bus.instr_valid && !stall;
                if (ev_len != 2'd0) begin
                    state_d      = StFlush;
                    flush_left_d = ev_len;
                end
            end
            StFlush: begin
                flush = 1'b1;
                if (ev_len != 2'd0) begin
                    flush_left_d = ev_len;
                end else begin
                    flush_left_d = flush_left_q - 2'd1;
                    if (flush_left_q <= 2'd1) begin
                        state_d      = StIdle;
                        flush_left_d = 2'd0;
                    end
                end
            end
            default: begin
                state_d      = StIdle;
                flush_left_d = 2'd0;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= StIdle;
            flush_left_q <= 2'd0;
        end else begin
            state_q      <= state_d;
            flush_left_q <= flush_left_d;
        end
    end

    assign bus.issue = issue;
    assign bus.stall = stall;
    assign bus.flush = flush;

`ifdef EXEC_HAZARD_PERF_CNT_EN
    logic [31:0] stall_cnt_q, stall_cnt_d;
    logic [31:0] flush_cnt_q, flush_cnt_d;

    always_comb begin
        stall_cnt_d = stall_cnt_q + {31'd0, stall};
        flush_cnt_d = flush_cnt_q + {31'd0, flush};
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            stall_cnt_q <= 32'd0;
            flush_cnt_q <= 32'd0;
        end else begin
            stall_cnt_q <= stall_cnt_d;
            flush_cnt_q <= flush_cnt_d;
        end
    end

    assign bus.stall_cnt = stall_cnt_q;
    assign bus.flush_cnt = flush_cnt_q;
`else
    // Perf counters not built.
`endif

endmodule

// File: tb/tb_exec_hazard_ctrl.sv
// Randomized self-checking bench for exec_hazard_ctrl against a pending-count/flush-length model.
// Also covers the directed hazard, flush and reset scenarios.
module tb_exec_hazard_ctrl;
    import hazard_pkg::*;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   checks   = 0;
    int   failures = 0;

    // Reference model: outstanding writes per register, remaining flush cycles.
    int          pend [32];
    bit          m_flush;
    int          m_left;
    int unsigned m_stall_cnt;
    int unsigned m_flush_cnt;

    always #5 clk = ~clk;

    exec_hazard_ctrl_if bus ();

    exec_hazard_ctrl dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    task automatic idle_inputs();
        bus.instr_valid       = 1'b0;
        bus.reg_rd_id         = 6'd0;
        bus.rs1_id            = 5'd0;
        bus.rs2_id            = 5'd0;
        bus.resolve           = 1'b0;
        bus.select_target_pc  = 1'b0;
        bus.squash_after_J    = 1'b0;
        bus.squash_after_JALR = 1'b0;
        bus.wb_valid          = 1'b0;
        bus.wb_rd_id          = 5'd0;
        bus.kill_valid        = 1'b0;
        bus.kill_rd_id        = 5'd0;
    endtask

    task automatic model_reset();
        for (int i = 0; i < 32; i++) pend[i] = 0;
        m_flush     = 1'b0;
        m_left      = 0;
        m_stall_cnt = 0;
        m_flush_cnt = 0;
    endtask

    // Called just after a falling edge with inputs already driven.
    task automatic step(input string tag);
        bit exp_stall, exp_issue, exp_flush;
        int rs1, rs2, rd, ev;
        #1;
        rs1 = int'(bus.rs1_id);
        rs2 = int'(bus.rs2_id);
        rd  = int'(bus.reg_rd_id[4:0]);
        exp_flush = m_flush;
        exp_stall = !m_flush && bus.instr_valid &&
                    ((rs1 != 0 && pend[rs1] > 0) || (rs2 != 0 && pend[rs2] > 0) ||
                     (bus.reg_rd_id[5] && pend[rd] >= 3));
        exp_issue = !m_flush && bus.instr_valid && !exp_stall;
        check_eq({tag, ".issue"}, {31'd0, bus.issue}, {31'd0, exp_issue});
        check_eq({tag, ".stall"}, {31'd0, bus.stall}, {31'd0, exp_stall});
        check_eq({tag, ".flush"}, {31'd0, bus.flush}, {31'd0, exp_flush});
`ifdef EXEC_HAZARD_PERF_CNT_EN
        check_eq({tag, ".stall_cnt"}, bus.stall_cnt, m_stall_cnt);
        check_eq({tag, ".flush_cnt"}, bus.flush_cnt, m_flush_cnt);
`endif
        @(posedge clk);
        if (rst) begin
            model_reset();
        end else begin
            if (exp_issue && bus.reg_rd_id[5] && rd != 0) pend[rd]++;
            if (bus.wb_valid && bus.wb_rd_id != 0 && pend[bus.wb_rd_id] > 0)
                pend[bus.wb_rd_id]--;
            if (bus.kill_valid && bus.kill_rd_id != 0 && pend[bus.kill_rd_id] > 0)
                pend[bus.kill_rd_id]--;
            m_stall_cnt += exp_stall;
            m_flush_cnt += exp_flush;
            if (bus.resolve && bus.select_target_pc) ev = 2;
            else if (bus.squash_after_JALR)         ev = 2;
            else if (bus.squash_after_J)            ev = 1;
            else                                    ev = 0;
            if (ev > 0) begin
                m_flush = 1'b1;
                m_left  = ev;
            end else if (m_flush) begin
                m_left--;
                if (m_left == 0) m_flush = 1'b0;
            end
        end
        @(negedge clk);
    endtask

    task automatic do_reset();
        idle_inputs();
        rst = 1'b1;
        step("rst");
        rst = 1'b0;
    endtask

    initial begin
        idle_inputs();
        model_reset();
        rst = 1'b1;
        repeat (2) @(negedge clk);
        rst = 1'b0;
        step("reset");

        // RAW on x5 until writeback.
        bus.instr_valid = 1'b1; bus.reg_rd_id = 6'h25;
        step("x5_issue");
        bus.reg_rd_id = 6'h00; bus.rs1_id = 5'd5;
        step("x5_stall0");
        step("x5_stall1");
        bus.wb_valid = 1'b1; bus.wb_rd_id = 5'd5;
        step("x5_wb");
        bus.wb_valid = 1'b0;
        step("x5_go");

        // x0 sources never stall; rd x0 never pends.
        do_reset();
        bus.instr_valid = 1'b1; bus.reg_rd_id = 6'h23;
        step("x0_pend3");
        bus.reg_rd_id = 6'h20;
        step("x0_rd0");
        step("x0_rd0b");
        bus.reg_rd_id = 6'h00;
        step("x0_src");

        // Taken branch: two flush cycles; J: one.
        do_reset();
        bus.instr_valid = 1'b1; bus.resolve = 1'b1; bus.select_target_pc = 1'b1;
        step("br_ev");
        bus.resolve = 1'b0; bus.select_target_pc = 1'b0;
        repeat (3) step("br_fl");
        bus.resolve = 1'b1;
        step("br_nt");
        bus.resolve = 1'b0; bus.squash_after_J = 1'b1;
        step("j_ev");
        bus.squash_after_J = 1'b0;
        repeat (2) step("j_fl");

        // J arriving in the second branch flush cycle restarts the flush.
        bus.resolve = 1'b1; bus.select_target_pc = 1'b1;
        step("rs_ev");
        bus.resolve = 1'b0; bus.select_target_pc = 1'b0;
        step("rs_fl1");
        bus.squash_after_J = 1'b1;
        step("rs_fl2");
        bus.squash_after_J = 1'b0;
        repeat (2) step("rs_fl3");

        // Saturation on x7, then paired wb+kill.
        do_reset();
        bus.instr_valid = 1'b1; bus.reg_rd_id = 6'h27;
        repeat (4) step("sat_x7");
        bus.wb_valid = 1'b1; bus.wb_rd_id = 5'd7; bus.kill_valid = 1'b1; bus.kill_rd_id = 5'd7;
        step("sat_wbkill");
        bus.wb_valid = 1'b0; bus.kill_valid = 1'b0; bus.reg_rd_id = 6'h00; bus.rs1_id = 5'd7;
        step("sat_after");
        bus.wb_valid = 1'b1;
        step("sat_wb");
        bus.wb_valid = 1'b0;
        step("sat_clear");

        // Reset in the first flush cycle with x3 pending.
        do_reset();
        bus.instr_valid = 1'b1; bus.reg_rd_id = 6'h23;
        step("rf_issue");
        bus.instr_valid = 1'b0; bus.reg_rd_id = 6'h00;
        bus.resolve = 1'b1; bus.select_target_pc = 1'b1;
        step("rf_ev");
        bus.resolve = 1'b0; bus.select_target_pc = 1'b0;
        rst = 1'b1;
        step("rf_rst");
        rst = 1'b0;
        bus.instr_valid = 1'b1; bus.rs1_id = 5'd3;
        step("rf_after");

        // Random traffic over a small register window to provoke hazards.
        for (int n = 0; n < 3000; n++) begin
            bit we;
            rst                   = ($urandom_range(0, 199) == 0);
            bus.instr_valid       = ($urandom_range(0, 3) != 0);
            we                    = 1'($urandom_range(0, 1));
            bus.reg_rd_id         = {we, 5'($urandom_range(0, 7))};
            bus.rs1_id            = 5'($urandom_range(0, 7));
            bus.rs2_id            = 5'($urandom_range(0, 7));
            bus.resolve           = ($urandom_range(0, 3) == 0);
            bus.select_target_pc  = 1'($urandom_range(0, 1));
            bus.squash_after_J    = ($urandom_range(0, 15) == 0);
            bus.squash_after_JALR = ($urandom_range(0, 15) == 0);
            bus.wb_valid          = 1'($urandom_range(0, 1));
            bus.wb_rd_id          = 5'($urandom_range(0, 7));
            bus.kill_valid        = ($urandom_range(0, 3) == 0);
            bus.kill_rd_id        = 5'($urandom_range(0, 7));
            step("rand");
        end
        rst = 1'b0;
        idle_inputs();
        step("end");

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/exec_hazard_ctrl.md
EXEC_HAZARD_CTRL -- requirements
Module: exec_hazard_ctrl

Interface
REQ-001 The block SHALL have one clock and one reset: clk; reset is synchronous and active-high, named rst.
REQ-002 clk  input  1  rising-edge clock for all state.
REQ-003 rst  input  1  synchronous active-high reset.
REQ-004 instr_valid  input  1  decode presents an instruction this cycle.
REQ-005 reg_rd_id  input  6  bit5 = destination write enable, bits 4:0 = destination register.
REQ-006 rs1_id, rs2_id  input  5 each  source registers of the decode instruction.
REQ-007 resolve, select_target_pc  input  1 each  branch resolved this cycle; redirect taken.
REQ-008 squash_after_J, squash_after_JALR  input  1 each  jump redirect requests.
REQ-009 wb_valid, wb_rd_id  input  1 / 5  retiring write clears one pending entry.
REQ-010 kill_valid, kill_rd_id  input  1 / 5  squashed in-flight write clears one pending entry.
REQ-011 issue  output  1  instruction accepted this cycle.
REQ-012 stall  output  1  instruction held due to hazard or scoreboard saturation.
REQ-013 flush  output  1  decode/fetch contents are invalid this cycle.

Function
REQ-014 Scoreboard: per register 1..31, a 2-bit pending count; register 0 SHALL never be pending and never be written.
REQ-015 stall SHALL be 1 when state is IDLE, instr_valid=1, and (rs1_id or rs2_id nonzero with count>0, or reg_rd_id[5]=1 with count[reg_rd_id[4:0]]=3); combinational.
REQ-016 issue SHALL be instr_valid & ~stall & (state==IDLE); combinational.
REQ-017 On issue with reg_rd_id[5]=1 and nonzero index, the count SHALL increment at the next edge.
REQ-018 wb_valid and kill_valid SHALL each decrement the named count by 1; both on one register decrement it by 2; counts SHALL saturate at 0 (no underflow).
REQ-019 Simultaneous increment and decrement on one register SHALL apply the net change in the same edge.
REQ-020 FSM states IDLE, FLUSH; counter flush_left, 2 bits.
REQ-021 In IDLE, event priority SHALL be: resolve&select_target_pc (load 2) > squash_after_JALR (load 2) > squash_after_J (load 1); on any event go to FLUSH at the next edge.
REQ-022 resolve with select_target_pc=0 SHALL NOT cause a flush.
REQ-023 In FLUSH: flush=1, issue=0, stall=0; flush_left decrements each cycle; return to IDLE after the cycle in which flush_left=1.
REQ-024 Squash events arriving in FLUSH SHALL reload flush_left with the new length (restart) and remain in FLUSH.
REQ-025 In IDLE flush SHALL be 0; an event cycle does not block issue in that cycle.
REQ-026 wb/kill decrements SHALL apply in every state, including FLUSH.

Reset
REQ-027 While rst=1 at an edge: all counts 0, state IDLE, flush_left 0; outputs issue=0, stall=0, flush=0 in the following cycle absent inputs.
REQ-028 Reset mid-FLUSH SHALL abort the flush at the next edge; reset dominates all simultaneous events.

Configuration
REQ-029 Macro EXEC_HAZARD_PERF_CNT_EN defined: outputs stall_cnt and flush_cnt, each 32-bit, increment on each stall / flush cycle, wrap at 2^32, reset to 0.
REQ-030 Without EXEC_HAZARD_PERF_CNT_EN: those ports and counters SHALL NOT exist; other behaviour is identical.

Structure
REQ-031 Package hazard_pkg SHALL hold the state enum, FLUSH_LEN_BR=2, FLUSH_LEN_JALR=2, FLUSH_LEN_J=1, and SB_CNT_MAX=3.
REQ-032 The scoreboard SHALL be one sub-module, hazard_scoreboard (counts, increment/decrement, lookup); FSM and outputs live in the top module.

Verification
REQ-033 Issue rd=x5 (reg_rd_id=6'h25), next cycle rs1=5 -> stall=1 until wb_valid wb_rd_id=5; issue=1 in the cycle after the wb edge.
REQ-034 Source rs1=0, rs2=0 with pending writes elsewhere -> never stalls; issue with reg_rd_id=6'h20 -> no count change.
REQ-035 resolve=1, select_target_pc=1 -> flush=1 for exactly 2 cycles, issue=0 throughout; squash_after_J alone -> flush for 1 cycle.
REQ-036 squash_after_J during the second FLUSH cycle of a branch -> flush extended by 1 more cycle (total 3).
REQ-037 Three issues to x7 without wb -> fourth rd=x7 stalls; simultaneous wb and kill on x7 -> count drops to 1.
REQ-038 rst asserted in first FLUSH cycle with x3 pending -> next cycle flush=0, rs1=3 issues without stall; perf counters (when compiled in) read 0.
